// File: rtl/periph_bus_mux.sv
// periph_bus_mux: registered peripheral bus decoder/multiplexer with bursts, a per-beat
// slave timeout, decode-error responses and a latched priority interrupt encoder.
module periph_bus_mux #(
  parameter int unsigned                XLEN       = 32,
  parameter int unsigned                NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*XLEN-1:0] SLV_BASE   =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*XLEN-1:0] SLV_MASK   = {4{32'hF000_0000}},
  parameter int unsigned                TIMEOUT    = 255,
  parameter int unsigned                CODE_W     = 5
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            m_addr,
  input  logic                       m_read,
  input  logic                       m_write,
  input  logic [XLEN-1:0]            m_wdata,
  input  logic [1:0]                 m_byte_size,
  input  logic [2:0]                 m_burst_len,
  input  logic                       read_ready,
  output logic [XLEN-1:0]            m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic                       s_read,
  output logic                       s_write,
  output logic [XLEN-1:0]            s_addr,
  output logic [XLEN-1:0]            s_wdata,
  output logic [1:0]                 s_byte_size,
  input  logic [NUM_SLAVES*XLEN-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  input  logic [NUM_SLAVES-1:0]      irq_in,
  input  logic                       irq_ack,
  output logic [CODE_W-1:0]          int_code,
  output logic                       int_valid
);

  localparam int unsigned     IdxW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned     TmrW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TmrW-1:0] TmrMax    = TmrW'(TIMEOUT);
  localparam logic [XLEN-1:0] BeatBytes = XLEN'(XLEN / 8);

  typedef enum logic [2:0] {StIdle, StAccess, StResp, StErr, StHold} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic [2:0]            beats_q, beats_d;
  logic                  is_rd_q, is_rd_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic [XLEN-1:0]       m_rdata_q, m_rdata_d;
  logic                  m_ready_q, m_ready_d;
  logic                  m_err_q, m_err_d;
  logic [NUM_SLAVES-1:0] s_sel_q, s_sel_d;
  logic                  s_read_q, s_read_d;
  logic                  s_write_q, s_write_d;
  logic [NUM_SLAVES-1:0] irq_q, irq_d;
  logic [NUM_SLAVES-1:0] pend_q, pend_d;
  logic [CODE_W-1:0]     int_code_q, int_code_d;
  logic                  int_valid_q, int_valid_d;

  logic                  dec_hit;
  logic [IdxW-1:0]       dec_idx;
  logic                  sel_ready;
  logic [XLEN-1:0]       sel_rdata;
  logic [NUM_SLAVES-1:0] irq_rise, ack_mask, pend_kept;

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NUM_SLAVES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IdxW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
        dec_hit = 1'b1;
        dec_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    beats_d   = beats_q;
    is_rd_d   = is_rd_q;
    timer_d   = timer_q;
    m_rdata_d = '0;
    m_ready_d = 1'b0;
    m_err_d   = 1'b0;
    s_sel_d   = '0;
    s_read_d  = 1'b0;
    s_write_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (m_read || m_write) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          size_d  = m_byte_size;
          beats_d = m_burst_len;
          is_rd_d = m_read;
          timer_d = '0;
          if (dec_hit && !(m_read && m_write)) begin
            idx_d     = dec_idx;
            state_d   = StAccess;
            s_sel_d   = onehot(dec_idx);
            s_read_d  = m_read;
            s_write_d = m_write;
          end else begin
            state_d   = StErr;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
          end
        end
      end
      StAccess: begin
        if (timer_q == TmrMax) begin
          state_d   = StErr;
          timer_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
        end else if (sel_ready) begin
          state_d   = StResp;
          timer_d   = '0;
          m_ready_d = 1'b1;
          m_rdata_d = is_rd_q ? sel_rdata : '0;
        end else begin
          timer_d = timer_q + 1'b1;
          // Strobes drop the cycle the timer expires; the error follows one cycle later.
          if (timer_d != TmrMax) begin
            s_sel_d   = onehot(idx_q);
            s_read_d  = is_rd_q;
            s_write_d = ~is_rd_q;
          end
        end
      end
      StResp: begin
        m_ready_d = 1'b1;
        m_rdata_d = m_rdata_q;
        if (!is_rd_q || read_ready) begin
          m_ready_d = 1'b0;
          m_rdata_d = '0;
          if (beats_q != 3'd0) begin
            addr_d    = addr_q + BeatBytes;
            beats_d   = beats_q - 3'd1;
            timer_d   = '0;
            state_d   = StAccess;
            s_sel_d   = onehot(idx_q);
            s_read_d  = is_rd_q;
            s_write_d = ~is_rd_q;
          end else begin
            state_d = StHold;
          end
        end
      end
      StErr:  state_d = StHold;
      StHold: if (!m_read && !m_write) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A fresh edge on the acknowledged bit keeps it pending.
  always_comb begin
    irq_d    = irq_in;
    irq_rise = irq_in & ~irq_q;
    ack_mask = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (irq_ack && (int_code_q == CODE_W'(i + 1))) ack_mask[i] = 1'b1;
    end
    pend_kept  = pend_q & ~(ack_mask & ~irq_rise);
    pend_d     = pend_kept | irq_rise;
    int_code_d = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (pend_kept[i]) int_code_d = CODE_W'(i + 1);
    end
    int_valid_d = (int_code_d != '0);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      beats_q     <= '0;
      is_rd_q     <= 1'b0;
      timer_q     <= '0;
      m_rdata_q   <= '0;
      m_ready_q   <= 1'b0;
      m_err_q     <= 1'b0;
      s_sel_q     <= '0;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
      irq_q       <= '0;
      pend_q      <= '0;
      int_code_q  <= '0;
      int_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      beats_q     <= beats_d;
      is_rd_q     <= is_rd_d;
      timer_q     <= timer_d;
      m_rdata_q   <= m_rdata_d;
      m_ready_q   <= m_ready_d;
      m_err_q     <= m_err_d;
      s_sel_q     <= s_sel_d;
      s_read_q    <= s_read_d;
      s_write_q   <= s_write_d;
      irq_q       <= irq_d;
      pend_q      <= pend_d;
      int_code_q  <= int_code_d;
      int_valid_q <= int_valid_d;
    end
  end

  assign m_rdata     = m_rdata_q;
  assign m_ready     = m_ready_q;
  assign m_err       = m_err_q;
  assign s_sel       = s_sel_q;
  assign s_read      = s_read_q;
  assign s_write     = s_write_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_byte_size = size_q;
  assign int_code    = int_code_q;
  assign int_valid   = int_valid_q;

endmodule

// File: tb/tb_periph_bus_mux.sv
// Bench for periph_bus_mux: per-transaction expected cycle plans built from the address map
// and handshake rules, plus directed interrupt and reset sequences.
module tb_periph_bus_mux;

  localparam int XLEN = 32;
  localparam int NS   = 4;
  localparam int TO   = 8;
  localparam int CW   = 5;

  logic              pclk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   m_addr, m_wdata, m_rdata, s_addr, s_wdata;
  logic              m_read, m_write, read_ready, m_ready, m_err, s_read, s_write;
  logic [1:0]        m_byte_size, s_byte_size;
  logic [2:0]        m_burst_len;
  logic [NS-1:0]     s_sel, s_ready, irq_in;
  logic [NS*XLEN-1:0] s_rdata;
  logic              irq_ack, int_valid;
  logic [CW-1:0]     int_code;

  periph_bus_mux #(
    .XLEN(XLEN), .NUM_SLAVES(NS), .TIMEOUT(TO), .CODE_W(CW)
  ) dut (
    .pclk(pclk), .rst(rst), .m_addr(m_addr), .m_read(m_read), .m_write(m_write),
    .m_wdata(m_wdata), .m_byte_size(m_byte_size), .m_burst_len(m_burst_len),
    .read_ready(read_ready), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_sel(s_sel), .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_byte_size(s_byte_size), .s_rdata(s_rdata), .s_ready(s_ready), .irq_in(irq_in),
    .irq_ack(irq_ack), .int_code(int_code), .int_valid(int_valid)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [NS-1:0] srdy;   // ready driven by the target slave this cycle
    logic          rr;
    logic          resp;
    logic [31:0]   sdata;
    logic [NS-1:0] sel;
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic          rdy;
    logic          err;
    logic [31:0]   rdata;
  } step_t;

  step_t       plan[$];
  int          wait_a[8];
  int          rrd_a[8];
  logic [31:0] rdat_a[8];
  int          cur_slv;
  int          vectors = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each slave owns one 256 MB region starting at i * 0x1000_0000.
  function automatic int decode(input logic [31:0] a);
    int region;
    region = int'(a >> 28);
    return (region < NS) ? region : -1;
  endfunction

  function automatic step_t zstep();
    step_t s;
    s.srdy = '0; s.rr = 1'b0; s.resp = 1'b0; s.sdata = '0; s.sel = '0; s.rd = 1'b0;
    s.wr = 1'b0; s.addr = '0; s.rdy = 1'b0; s.err = 1'b0; s.rdata = '0;
    return s;
  endfunction

  task automatic build(input logic [31:0] a, input logic r, input logic w, input int blen);
    step_t s;
    int    n;
    plan.delete();
    cur_slv = decode(a);
    if (cur_slv < 0 || (r && w)) begin
      s = zstep(); s.rdy = 1'b1; s.err = 1'b1; plan.push_back(s);
    end else begin
      for (int b = 0; b <= blen; b++) begin
        n = (wait_a[b] >= TO) ? TO : wait_a[b] + 1;
        for (int c = 0; c < n; c++) begin
          s = zstep(); s.sel[cur_slv] = 1'b1; s.rd = r; s.wr = w; s.addr = a + 32'(4 * b);
          if (c == wait_a[b]) begin s.srdy[cur_slv] = 1'b1; s.sdata = rdat_a[b]; end
          plan.push_back(s);
        end
        if (wait_a[b] >= TO) begin
          plan.push_back(zstep());
          s = zstep(); s.rdy = 1'b1; s.err = 1'b1; plan.push_back(s);
          break;
        end
        n = r ? rrd_a[b] + 1 : 1;
        for (int c = 0; c < n; c++) begin
          s = zstep(); s.resp = 1'b1; s.rdy = 1'b1; s.rdata = r ? rdat_a[b] : 32'h0;
          s.rr = (c == n - 1); plan.push_back(s);
        end
      end
    end
    plan.push_back(zstep());
    plan.push_back(zstep());
  endtask

  task automatic run(input logic [31:0] a, input logic r, input logic w, input int blen,
                     input logic [1:0] sz, input logic [31:0] wd);
    step_t p;
    build(a, r, w, blen);
    m_addr = a; m_read = r; m_write = w; m_burst_len = 3'(blen); m_byte_size = sz;
    m_wdata = wd;
    while (plan.size() > 0) begin
      p = plan.pop_front();
      tick();
      check("s_sel", 32'(s_sel), 32'(p.sel));
      check("s_read", 32'(s_read), 32'(p.rd));
      check("s_write", 32'(s_write), 32'(p.wr));
      if (p.sel != '0) begin
        check("s_addr", s_addr, p.addr);
        check("s_wdata", s_wdata, wd);
        check("s_byte_size", 32'(s_byte_size), 32'(sz));
      end
      check("m_ready", 32'(m_ready), 32'(p.rdy));
      check("m_err", 32'(m_err), 32'(p.err));
      check("m_rdata", m_rdata, p.rdata);
      for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
      if (cur_slv >= 0) begin
        if (p.srdy[cur_slv]) s_rdata[cur_slv*32 +: 32] = p.sdata;
        s_ready = p.srdy | (NS'($urandom) & ~(NS'(1) << cur_slv));
      end else begin
        s_ready = NS'($urandom);
      end
      read_ready = p.resp ? p.rr : 1'($urandom);
    end
    m_read = 1'b0; m_write = 1'b0; s_ready = '0; read_ready = 1'b0;
    tick();
    check("idle_sel", 32'(s_sel), 32'h0);
    check("idle_ready", 32'(m_ready), 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_rdata"}, m_rdata, 32'h0);
    check({tag, "_m_ready"}, 32'(m_ready), 32'h0);
    check({tag, "_m_err"}, 32'(m_err), 32'h0);
    check({tag, "_s_sel"}, 32'(s_sel), 32'h0);
    check({tag, "_s_strb"}, 32'({s_read, s_write}), 32'h0);
    check({tag, "_s_addr"}, s_addr, 32'h0);
    check({tag, "_s_wdata"}, s_wdata, 32'h0);
    check({tag, "_s_size"}, 32'(s_byte_size), 32'h0);
    check({tag, "_int_code"}, 32'(int_code), 32'h0);
    check({tag, "_int_valid"}, 32'(int_valid), 32'h0);
  endtask

  task automatic check_irq(input string tag, input int code);
    check(tag, 32'(int_code), 32'(code));
    check({tag, "_v"}, 32'(int_valid), 32'(code != 0));
  endtask

  initial begin
    int          k;
    logic        r, w;
    logic [31:0] a;
    int          blen;

    rst = 1'b1; m_addr = '0; m_read = 1'b0; m_write = 1'b0; m_wdata = '0;
    m_byte_size = '0; m_burst_len = '0; read_ready = 1'b0; s_rdata = '0; s_ready = '0;
    irq_in = '0; irq_ack = 1'b0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;

    wait_a[0] = 2; rrd_a[0] = 3; rdat_a[0] = 32'hDEAD_BEEF;
    run(32'h2000_0010, 1'b1, 1'b0, 0, 2'd2, 32'h0);

    for (int b = 0; b < 4; b++) wait_a[b] = 0;
    run(32'h1000_0000, 1'b0, 1'b1, 3, 2'd2, 32'hCAFE_0001);

    run(32'h5000_0000, 1'b1, 1'b0, 0, 2'd0, 32'h0);
    run(32'h0000_0040, 1'b1, 1'b1, 0, 2'd1, 32'h1234_5678);

    wait_a[0] = 100;
    run(32'h0000_0100, 1'b1, 1'b0, 0, 2'd2, 32'h0);

    wait_a[0] = TO - 1; rrd_a[0] = 0; rdat_a[0] = 32'hA5A5_0F0F;
    run(32'h3000_0004, 1'b1, 1'b0, 0, 2'd2, 32'h0);

    // Burst running past the top of slave 1's region stays on slave 1.
    wait_a[0] = 1; wait_a[1] = 0; wait_a[2] = 2; wait_a[3] = 0;
    for (int b = 0; b < 4; b++) begin rrd_a[b] = b % 2; rdat_a[b] = 32'h1111_0000 + b; end
    run(32'h1FFF_FFF8, 1'b1, 1'b0, 3, 2'd2, 32'h0);

    wait_a[0] = 0; wait_a[1] = TO + 3; wait_a[2] = 0;
    run(32'h2000_0100, 1'b0, 1'b1, 2, 2'd0, 32'h0BAD_F00D);

    repeat (60) begin
      k    = $urandom_range(0, 7);
      r    = (k < 4) || (k == 7);
      w    = (k >= 4);
      a    = {4'($urandom_range(0, 5)), 28'($urandom)};
      blen = $urandom_range(0, 7);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) < 9) wait_a[b] = $urandom_range(0, 3);
        else wait_a[b] = ($urandom_range(0, 1) == 0) ? TO - 1 : TO + 5;
        rrd_a[b]  = $urandom_range(0, 2);
        rdat_a[b] = $urandom;
      end
      run(a, r, w, blen, 2'($urandom), $urandom);
    end

    // Reset in the middle of an access to a slave that never answers.
    m_addr = 32'h3000_0000; m_read = 1'b1; m_write = 1'b0; m_burst_len = 3'd0;
    m_byte_size = 2'd2; s_ready = '0;
    tick();
    check("rst_pre_sel", 32'(s_sel), 32'h8);
    tick();
    rst = 1'b1; m_read = 1'b0;
    tick();
    check_zero("rst_mid");
    rst = 1'b0;
    tick();
    check("rst_post_ready", 32'(m_ready), 32'h0);
    check("rst_post_err", 32'(m_err), 32'h0);
    wait_a[0] = 1; rrd_a[0] = 0; rdat_a[0] = 32'h7777_1234;
    run(32'h3000_0020, 1'b1, 1'b0, 0, 2'd2, 32'h0);

    irq_in = 4'b1010;
    tick(); check_irq("irq_c1", 0);
    tick(); check_irq("irq_c2", 2);
    irq_ack = 1'b1;
    tick(); check_irq("irq_ack1", 4);
    tick(); check_irq("irq_ack2", 0);
    irq_ack = 1'b0;
    repeat (3) tick();
    check_irq("irq_level", 0);
    irq_in = 4'b1000; tick();
    irq_in = 4'b1010; tick();
    tick(); check_irq("irq_rerise", 2);
    irq_in = 4'b1000; tick();
    irq_in = 4'b1010; irq_ack = 1'b1;
    tick(); check_irq("irq_ack_rise", 2);
    irq_ack = 1'b0;
    tick(); check_irq("irq_hold", 2);
    irq_ack = 1'b1;
    tick(); check_irq("irq_clr", 0);
    irq_in = 4'b1011;
    tick(); check_irq("irq_ack_none", 0);
    irq_ack = 1'b0;
    tick(); check_irq("irq_new", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
